// File: rtl/regbank_param_if.sv
// regbank_param_if: read/write port bundle of the register bank; the decode and
// write-back side is the master and the bank is the slave.
interface regbank_param_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] a;
   logic [ADDR_W-1:0] b;
   logic [ADDR_W-1:0] c;
   logic              w;
   logic [DATA_W-1:0] dataC;
   logic [DATA_W-1:0] dataA;
   logic [DATA_W-1:0] dataB;
   logic              busy;
   modport master (output a, b, c, w, dataC, input dataA, dataB, busy);
   modport slave  (input a, b, c, w, dataC, output dataA, dataB, busy);
endinterface

// File: rtl/regbank_param.sv
// regbank_param: DEPTH x DATA_W register file (2 comb reads, 1 write), reset clear sweep, hardwired zero reg.
// Define REGBANK_BYPASS_EN for same-cycle write-to-read forwarding.
module regbank_param #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input logic            clk,
   input logic            rst,
   regbank_param_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
   typedef enum logic {CLEAR, READY} state_t;
   state_t            state, nextState;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wrEn;
   logic              fwdA, fwdB;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= nextState;
         if (state == CLEAR) ptr <= ptr + ADDR_W'(1);
      end
   end
   // ptr wraps to 0 on its own at the last sweep edge
   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) mem[ptr] <= '0;
      else if (!rst && wrEn) mem[bus.c] <= bus.dataC;
   end
   always_comb begin
      nextState = (state == CLEAR && &ptr) ? READY : state;
      wrEn      = state == READY && bus.w && bus.c != ZR;
`ifdef REGBANK_BYPASS_EN
      fwdA      = wrEn && bus.c == bus.a;
      fwdB      = wrEn && bus.c == bus.b;
`else
      fwdA      = 1'b0;
      fwdB      = 1'b0;
`endif
      bus.busy  = state == CLEAR;
      bus.dataA = (state == CLEAR || bus.a == ZR) ? '0 : fwdA ? bus.dataC : mem[bus.a];
      bus.dataB = (state == CLEAR || bus.b == ZR) ? '0 : fwdB ? bus.dataC : mem[bus.b];
   end
endmodule

// File: tb/tb_regbank_param.sv
// tb_regbank_param: randomized and directed checks of regbank_param against a behavioural model,
// plus a small DATA_W=32/ADDR_W=3/ZERO_REG=0 instance.
module tb_regbank_param;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rstS = 1'b0;
   always #5 clk = ~clk;

   regbank_param_if #(.DATA_W(64), .ADDR_W(5)) bus ();
   regbank_param_if #(.DATA_W(32), .ADDR_W(3)) sbus ();

   regbank_param #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (.clk(clk), .rst(rst), .bus(bus));
   regbank_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) dutS (.clk(clk), .rst(rstS), .bus(sbus));

`ifdef REGBANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   logic [63:0] model [32];
   int busyLeft = 0;
   bit known = 1'b0;
   logic [63:0] obsA, obsB;
   logic obsBusy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] expRead(input logic [4:0] addr, input logic [4:0] wc,
                                           input logic we, input logic [63:0] wd);
      if (busyLeft > 0 || addr == 5'd31) return 64'd0;
      if (BYP && we && wc == addr) return wd;
      return model[addr];
   endfunction

   // one clock: drive at negedge, check combinational reads, then advance the model at posedge
   task automatic cycle(input logic r, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] wc, input logic we, input logic [63:0] wd);
      @(negedge clk);
      rst = r; bus.a = ra; bus.b = rb; bus.c = wc; bus.w = we; bus.dataC = wd;
      #1;
      obsA = bus.dataA; obsB = bus.dataB; obsBusy = bus.busy;
      if (known) begin
         check("busy", 64'(obsBusy), 64'(busyLeft > 0));
         check("dataA", obsA, expRead(ra, wc, we, wd));
         check("dataB", obsB, expRead(rb, wc, we, wd));
      end
      @(posedge clk);
      if (r) begin
         busyLeft = 32;
         known = 1'b1;
         for (int i = 0; i < 32; i++) model[i] = 64'd0;
      end else if (busyLeft > 0) busyLeft--;
      else if (we && wc != 5'd31) model[wc] = wd;
   endtask

   task automatic busyLength(input string tag);
      int n = 0;
      for (int k = 0; k < 100; k++) begin
         cycle(1'b0, 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
               5'($urandom_range(30, 0)), 1'b1, {$urandom, $urandom});
         if (!obsBusy) break;
         n++;
      end
      check(tag, 64'(n), 64'd32);
   endtask

   initial begin
      sbus.a = '0; sbus.b = '0; sbus.c = '0; sbus.w = 1'b0; sbus.dataC = '0;
      cycle(1'b1, 0, 0, 0, 1'b0, 0);
      busyLength("busyLen");
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, 5'(i), 5'(31 - i), 5'd0, 1'b0, 0);
         if (i < 31 && model[i] == 64'd0) check("clearRd", obsA, 64'd0);
      end
      cycle(1'b0, 0, 0, 5'd5, 1'b1, 64'hDEAD_BEEF_0123_4567);
      cycle(1'b0, 0, 0, 5'd6, 1'b1, 64'h1);
      cycle(1'b0, 5'd5, 5'd6, 0, 1'b0, 0);
      check("rd5", obsA, 64'hDEAD_BEEF_0123_4567);
      check("rd6", obsB, 64'h1);
      cycle(1'b0, 0, 0, 5'd30, 1'b1, 64'h30);
      cycle(1'b0, 0, 0, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle(1'b0, 5'd31, 5'd30, 0, 1'b0, 0);
      check("zeroReg", obsA, 64'd0);
      check("rd30", obsB, 64'h30);
      cycle(1'b0, 0, 0, 5'd7, 1'b1, 64'hA);
      cycle(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 64'hB);
      check("fwdA", obsA, BYP ? 64'hB : 64'hA);
      check("fwdB", obsB, BYP ? 64'hB : 64'hA);
      cycle(1'b0, 5'd7, 5'd7, 0, 1'b0, 0);
      check("afterWr", obsA, 64'hB);
      cycle(1'b1, 0, 0, 0, 1'b0, 0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 64'hC);
      cycle(1'b1, 0, 0, 5'd7, 1'b1, 64'hD);
      busyLength("busyLen2");
      cycle(1'b0, 5'd7, 5'd5, 0, 1'b0, 0);
      check("rd7clr", obsA, 64'd0);
      check("rd5clr", obsB, 64'd0);
      for (int i = 0; i < 500; i++) begin
         logic [4:0] ra = 5'($urandom_range(31, 0));
         logic [4:0] wc = ($urandom_range(3, 0) == 0) ? ra : 5'($urandom_range(31, 0));
         cycle($urandom_range(149, 0) == 0, ra, 5'($urandom_range(31, 0)), wc,
               1'($urandom), {$urandom, $urandom});
      end
      bus.w = 1'b0;
      @(negedge clk) rstS = 1'b1;
      @(negedge clk) rstS = 1'b0;
      #1;
      begin
         int n = 0;
         while (sbus.busy && n < 100) begin
            n++;
            @(negedge clk);
            #1;
         end
         check("sBusyLen", 64'(n), 64'd8);
      end
      @(negedge clk) begin sbus.w = 1'b1; sbus.c = 3'd0; sbus.dataC = 32'h5; end
      @(negedge clk) begin sbus.c = 3'd7; sbus.dataC = 32'h8000_0001; end
      @(negedge clk) begin sbus.w = 1'b0; sbus.a = 3'd0; sbus.b = 3'd7; end
      #1;
      check("sZero", 64'(sbus.dataA), 64'd0);
      check("sRd7", 64'(sbus.dataB), 64'h8000_0001);
      check("sBusy", 64'(sbus.busy), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
